// File: rtl/retire_sync_pkg.sv
// retire_sync_pkg
//   Shared types and helpers for the lock-step retirement synchronizer.
//   - sync_state_e   : RUN (nobody waiting), WAIT (some cores parked), HALT (diverged)
//   - wait_cnt_width : width needed to count WAIT cycles up to max_wait
package retire_sync_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } sync_state_e;

  function automatic int wait_cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/retire_sync.sv
// retire_sync
//   Lock-step retirement synchronizer. Each core's clock enable is dropped
//   once it has retired and re-raised only when every active core has
//   retired the same instruction. A core that stays silent too long while
//   others wait halts all cores and raises a sticky divergence flag.
//
// Ports
//   clk_i         shared clock
//   rst_i         asynchronous active-high reset
//   retire_i      per-core retire strobe (qualified by en_o and active_i)
//   active_i      per-core participation mask (0 = never blocks a sync)
//   en_o          per-core clock enable, registered
//   retire_o      one-cycle pulse per synchronized retirement, registered
//   retire_cnt_o  count of synchronized retirements, wraps
//   diverge_o     sticky divergence flag, cleared only by reset
module retire_sync
  import retire_sync_pkg::*;
#(
  parameter int N_CORES  = 2,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_CORES-1:0] retire_i,
  input  logic [N_CORES-1:0] active_i,
  output logic [N_CORES-1:0] en_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   retire_cnt_o,
  output logic               diverge_o
);

  localparam int                WAIT_W    = wait_cnt_width(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  sync_state_e        state;
  logic [N_CORES-1:0] arrived;
  logic [WAIT_W-1:0]  wait_cnt;

  logic [N_CORES-1:0] events;
  logic [N_CORES-1:0] pending;
  logic               sync;

  // A retire only counts while the core is enabled and participating.
  // Sync needs every active core covered by an earlier or current arrival;
  // an all-zero mask never syncs.
  always_comb begin
    events  = retire_i & en_o & active_i;
    pending = arrived | events;
    sync    = (state != HALT) && (active_i != '0) && ((active_i & ~pending) == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RUN;
      arrived      <= '0;
      wait_cnt     <= '0;
      en_o         <= '1;
      retire_o     <= 1'b0;
      retire_cnt_o <= '0;
      diverge_o    <= 1'b0;
    end else begin
      retire_o <= 1'b0;
      unique case (state)
        RUN, WAIT: begin
          if (sync) begin
            // Sync wins over a timeout landing in the same cycle.
            state        <= RUN;
            arrived      <= '0;
            wait_cnt     <= '0;
            en_o         <= '1;
            retire_o     <= 1'b1;
            retire_cnt_o <= retire_cnt_o + 1'b1;
          end else if ((state == WAIT) && (wait_cnt == WAIT_LAST)) begin
            state     <= HALT;
            en_o      <= '0;
            diverge_o <= 1'b1;
          end else begin
            // Park arrived cores; inactive cores keep running even if a
            // stale arrival bit is still recorded for them.
            arrived  <= pending;
            en_o     <= ~(pending & active_i);
            state    <= (pending != '0) ? WAIT : RUN;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
          end
        end
        HALT: begin
          en_o      <= '0;
          diverge_o <= 1'b1;
        end
        default: begin
          state <= HALT;
          en_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_sync.sv
// tb_retire_sync
//   Bench for retire_sync (3 cores, MAX_WAIT=4, 4-bit counter). A
//   behavioural model tracks which active cores have retired and since
//   which cycle the oldest one has been waiting; a compare process checks
//   every DUT output against it on each falling edge. Directed sequences
//   with literal expectations are followed by randomized traffic.
module tb_retire_sync;

  localparam int N        = 3;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     retire;
  logic [N-1:0]     active;
  logic [N-1:0]     en;
  logic             ret;
  logic [CNT_W-1:0] cnt;
  logic             div;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  retire_sync #(.N_CORES(N), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .retire_i     (retire),
    .active_i     (active),
    .en_o         (en),
    .retire_o     (ret),
    .retire_cnt_o (cnt),
    .diverge_o    (div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit     m_arr [N];   // core has retired and is waiting
  bit     m_en  [N];
  bit     m_ret;
  int     m_cnt;
  bit     m_halt;
  bit     m_waiting;
  longint m_t0;        // cycle of the first arrival of the current wait
  longint m_cycle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_arr[i] = 0; m_en[i] = 1; end
      m_ret = 0; m_cnt = 0; m_halt = 0; m_waiting = 0; m_t0 = 0; m_cycle = 0;
    end else begin
      m_ret = 0;
      if (!m_halt) begin
        bit ev [N];
        bit any_active, all_in, any_ev;
        any_active = 0; all_in = 1; any_ev = 0;
        for (int i = 0; i < N; i++) begin
          ev[i] = retire[i] && m_en[i] && active[i];
          if (ev[i]) any_ev = 1;
          if (active[i]) begin
            any_active = 1;
            if (!(m_arr[i] || ev[i])) all_in = 0;
          end
        end
        if (any_active && all_in) begin
          for (int i = 0; i < N; i++) m_arr[i] = 0;
          m_ret = 1;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_waiting = 0;
        end else begin
          if (!m_waiting && any_ev) begin
            m_waiting = 1;
            m_t0 = m_cycle;
          end
          for (int i = 0; i < N; i++) if (ev[i]) m_arr[i] = 1;
          if (m_waiting && (m_cycle - m_t0 >= MAX_WAIT)) m_halt = 1;
        end
      end
      for (int i = 0; i < N; i++) m_en[i] = m_halt ? 0 : !(m_arr[i] && active[i]);
      m_cycle++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_en();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_en[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_en",  32'(en),  32'(model_en()));
      check("model_ret", 32'(ret), 32'(m_ret));
      check("model_cnt", 32'(cnt), 32'(m_cnt));
      check("model_div", 32'(div), 32'(m_halt));
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs for one cycle; returns just after the sampling edge.
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] a);
    retire = r;
    active = a;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},  32'(en),  32'h7);
    check({tag, "_ret"}, 32'(ret), 32'h0);
    check({tag, "_cnt"}, 32'(cnt), 32'h0);
    check({tag, "_div"}, 32'(div), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p [N];
    rst = 1'b1; retire = '0; active = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    chk_on = 1;

    // Simultaneous retire: pulse next cycle, no freeze.
    tick(3'b011, 3'b011);
    check("both_ret", 32'(ret), 1); check("both_en", 32'(en), 32'h7); check("both_cnt", 32'(cnt), 1);
    tick(3'b000, 3'b011);
    check("both_ret_low", 32'(ret), 0);

    // Core0 early, core1 three cycles later; core0 retire while frozen is ignored.
    tick(3'b001, 3'b011);
    check("early_en", 32'(en), 32'h6);
    tick(3'b001, 3'b011);
    check("frozen_en", 32'(en), 32'h6);
    tick(3'b000, 3'b011);
    check("frozen_ret", 32'(ret), 0);
    tick(3'b010, 3'b011);
    check("late_ret", 32'(ret), 1); check("late_en", 32'(en), 32'h7); check("late_cnt", 32'(cnt), 2);

    // Core1 excluded, cores 0 and 2 retire every cycle: back-to-back pulses.
    for (int k = 0; k < 10; k++) begin
      tick(3'b101, 3'b101);
      check("b2b_ret", 32'(ret), 1);
      check("b2b_en1", 32'(en[1]), 1);
    end
    check("b2b_cnt", 32'(cnt), 12);

    // Dropping the lagging core from the mask completes the sync.
    tick(3'b001, 3'b011);
    tick(3'b000, 3'b011);
    check("mask_wait_en", 32'(en), 32'h6);
    tick(3'b000, 3'b001);
    check("mask_ret", 32'(ret), 1); check("mask_en", 32'(en), 32'h7); check("mask_cnt", 32'(cnt), 13);

    // Timeout: diverge after MAX_WAIT frozen cycles, held until reset.
    tick(3'b001, 3'b011);
    for (int k = 0; k < MAX_WAIT - 1; k++) begin
      tick(3'b000, 3'b011);
      check("to_pre_div", 32'(div), 0);
    end
    tick(3'b000, 3'b011);
    check("to_div", 32'(div), 1); check("to_en", 32'(en), 32'h0);
    tick(3'b011, 3'b011);
    tick(3'b011, 3'b011);
    check("halt_div", 32'(div), 1); check("halt_en", 32'(en), 32'h0);
    check("halt_ret", 32'(ret), 0); check("halt_cnt", 32'(cnt), 13);
    pulse_reset();
    check_reset_vals("halt_rst");
    #1 rst = 1'b0;

    // Sync in the last WAIT cycle beats the timeout.
    tick(3'b001, 3'b011);
    for (int k = 0; k < MAX_WAIT - 1; k++) tick(3'b000, 3'b011);
    tick(3'b010, 3'b011);
    check("last_ret", 32'(ret), 1); check("last_div", 32'(div), 0); check("last_en", 32'(en), 32'h7);

    // Counter wrap: 17 syncs since reset leaves 1.
    for (int k = 0; k < 15; k++) tick(3'b011, 3'b011);
    check("wrap_zero", 32'(cnt), 0);
    tick(3'b011, 3'b011);
    check("wrap_cnt", 32'(cnt), 1);

    // Asynchronous reset in the middle of a wait.
    tick(3'b001, 3'b011);
    check("midwait_en", 32'(en), 32'h6);
    pulse_reset();
    check_reset_vals("wait_rst");
    #1 rst = 1'b0;

    // Nobody active: no sync, everything enabled.
    for (int k = 0; k < 4; k++) begin
      tick(3'b111, 3'b000);
      check("idle_ret", 32'(ret), 0); check("idle_en", 32'(en), 32'h7);
    end

    // Randomized traffic; per-epoch retire probabilities so some waits time out.
    for (int e = 0; e < 30; e++) begin
      logic [N-1:0] a;
      for (int i = 0; i < N; i++) p[i] = (e % 4 == 3) ? $urandom_range(0, 3) * 30 : 30 + $urandom_range(0, 60);
      a = N'($urandom_range(1, 7));
      for (int k = 0; k < 100; k++) begin
        logic [N-1:0] r;
        if ($urandom_range(0, 24) == 0) a = N'($urandom_range(0, 7));
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 99) < p[i]);
        tick(r, a);
        if (m_halt && $urandom_range(0, 3) == 0) begin
          pulse_reset();
          #1 rst = 1'b0;
        end
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_sync.md
# retire_sync

Lock-step retirement synchronizer for N_CORES cores that run on one shared clock. The block drives a per-core clock enable so that each instruction retirement is committed in lock-step across all active cores. A core that retires early is frozen until every other active core has retired the same instruction. The block adds a retirement counter, a per-core participation mask, and a divergence timeout that halts all cores. It sits between the cores' retire outputs and their clock-enable inputs in the contract-checking harness.

## Interface
- N_CORES, 2: number of synchronized cores; must be ≥ 2.
- MAX_WAIT, 16: maximum consecutive WAIT cycles before divergence is declared; must be ≥ 1.
- CNT_W, 32: width of the retirement counter.

- clk_i  in  1  shared clock.
- rst_i  in  1  reset, asynchronous, active-high.
- retire_i  in  N_CORES  per-core retire strobe; bit i is meaningful only while en_o[i]=1.
- active_i  in  N_CORES  participation mask; 0 = core excluded from synchronization.
- en_o  out  N_CORES  per-core clock enable, registered.
- retire_o  out  1  one-cycle pulse per synchronized retirement, registered.
- retire_cnt_o  out  CNT_W  count of synchronized retirements.
- diverge_o  out  1  sticky divergence flag.

## Operation
- Event for core i in cycle t: retire_i[i] & en_o[i] & active_i[i].
- arrived register (N_CORES bits) holds cores that retired and are waiting.
- Sync in cycle t when (arrived | events) ⊇ active_i and the OR is nonzero.
- On sync, at edge t+1:
  - retire_o=1 for one cycle.
  - arrived cleared.
  - all en_o=1.
  - retire_cnt_o increments, wrapping modulo 2^CNT_W.
- Non-sync event for core i: arrived[i] set and en_o[i]=0 from t+1.
- Inactive cores always have en_o=1 and never block a sync.
- Mask is evaluated each cycle:
  - Clearing active_i[k] for the only lagging core k completes the sync in that cycle.
  - Bits of arrived for cores that become inactive are ignored and are cleared on the next sync.
- active_i=0 for all cores: no sync, retire_o stays 0, all en_o=1.
- FSM states (enum):
  - RUN: arrived=0.
  - WAIT: arrived≠0.
  - HALT.
- FSM transitions:
  - RUN→WAIT on a non-sync event.
  - WAIT→RUN on sync.
  - WAIT→HALT on timeout.
  - HALT is left only by reset.
- wait_cnt ($clog2(MAX_WAIT+1) bits):
  - Set to 0 when entering WAIT.
  - Increments each WAIT cycle without a sync.
  - Timeout occurs when wait_cnt reaches MAX_WAIT-1 and there is no sync that cycle.
- HALT: diverge_o=1, all en_o=0, retire_o=0, retire_i ignored.

## Timing
- Reset values: en_o all 1, retire_o=0, retire_cnt_o=0, diverge_o=0, state RUN, arrived=0, wait_cnt=0.
- Simultaneous events from all active cores in cycle t: retire_o=1 at t+1; en_o is never deasserted.
- A first non-sync event at t freezes that core from t+1.
- The last arrival at cycle u releases all cores at u+1.
- Worst-case freeze is MAX_WAIT cycles; with no sync, diverge_o rises at t+1+MAX_WAIT.
- Sync in the final WAIT cycle takes priority over the timeout.
- retire_o is never asserted on two consecutive cycles unless all active cores retire every cycle. Back-to-back syncs are legal.
- Reset mid-WAIT or mid-HALT returns to reset values immediately, since reset is asynchronous.

## Structure
- retire_sync_pkg holds:
  - the state enum (RUN, WAIT, HALT);
  - a localparam function for the wait_cnt width.
- Single module; no sub-module needed. Arrival tracking, the FSM, and the counters are inline.

## Test plan
- N_CORES=2, active=11, both retire at cycle 5 → retire_o=1 at cycle 6, en_o stays 11, retire_cnt_o=1.
- Core0 retires at 5, core1 at 8 → en_o=10 (core0 frozen) during cycles 6–8, en_o=11 and retire_o=1 at 9, retire_cnt_o=1.
- N_CORES=3, active=101, core1 never retires; cores 0 and 2 retire together every cycle for 10 cycles → 10 retire_o pulses, en_o[1]=1 throughout.
- MAX_WAIT=4, core0 retires at 5, core1 silent → diverge_o=1 and en_o=00 at cycle 10; they hold until rst_i, and reset restores en_o=11.
- Core0 waiting, active_i[1] cleared at cycle 7 → retire_o=1 at cycle 8, en_o=11.
- CNT_W=4, 17 syncs → retire_cnt_o=1 (wrap); rst_i asserted mid-WAIT → all outputs take reset values asynchronously.
